dmem_ws: RTL and testbench

Parametrised, wait-state-capable data memory for the `hvcore` data port. It replaces the fixed single-cycle data memory in core benches and SoC builds. It models slow data memory: requests are accepted, held for a configurable number of wait states, then completed with a one-cycle `ack` and `rdata_valid` strobe. It also adds byte-lane writes and out-of-range error reporting.

---
 rtl/dmem_ws.sv | 174 +++++++++++++++++
 tb/tb_dmem_ws.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ws.sv
// ============================================================================
// Module   : dmem_ws
// Brief    : Wait-state data memory with byte-lane writes and range errors.
//            Optional random wait states: define DMEM_RANDOM_WS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ws #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int WS     = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                wr,
   input  logic [31:0]         addr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata,
   output logic                rdata_valid,
   output logic                ack,
   output logic                busy,
   output logic                err
);

   localparam int         c_nbe   = DATA_W / 8;
   localparam int         c_depth = 2 ** ADDR_W;
   localparam logic [2:0] c_ws    = 3'(WS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DATA_W-1:0]   r_mem [c_depth];

   logic                r_wr;
   logic [ADDR_W-1:0]   r_idx;
   logic [c_nbe-1:0]    r_be;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_oor;
   logic [2:0]          r_wcnt;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_accept;
   logic                w_commit;
   logic                w_oor;
   logic [ADDR_W-1:0]   w_idx;
   logic [2:0]          w_wait;
   logic                w_unused_addr;

   logic                w_c_wr;
   logic [ADDR_W-1:0]   w_c_idx;
   logic [c_nbe-1:0]    w_c_be;
   logic [DATA_W-1:0]   w_c_wdata;
   logic                w_c_oor;

   assign w_idx         = addr[ADDR_W+1:2];
   assign w_oor         = |addr[31:ADDR_W+2];
   assign w_unused_addr = ^addr[1:0];

`ifdef DMEM_RANDOM_WS_EN
   logic [7:0] r_lfsr;
   logic       w_fb;

   // Taps x^8+x^6+x^5+x^4+1; sampled for this request, then advanced
   assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_wait = (r_lfsr[2:0] < c_ws) ? r_lfsr[2:0] : c_ws;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr <= 8'h01;
      end else if (w_accept) begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
      end
   end
`else
   assign w_wait = c_ws;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE, S_ACK: begin
            if (en) begin
               w_accept    = 1'b1;
               w_commit    = (w_wait == 3'd0);
               w_state_nxt = (w_wait == 3'd0) ? S_ACK : S_WAIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_wcnt <= 3'd1) begin
               w_commit    = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A zero-wait access commits on its accept edge, before the latches update
   always_comb begin
      w_c_wr    = wr;
      w_c_idx   = w_idx;
      w_c_be    = be;
      w_c_wdata = wdata;
      w_c_oor   = w_oor;
      if (r_state == S_WAIT) begin
         w_c_wr    = r_wr;
         w_c_idx   = r_idx;
         w_c_be    = r_be;
         w_c_wdata = r_wdata;
         w_c_oor   = r_oor;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_idx   <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_oor   <= 1'b0;
         r_wcnt  <= 3'd0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_wr    <= wr;
            r_idx   <= w_idx;
            r_be    <= be;
            r_wdata <= wdata;
            r_oor   <= w_oor;
            r_wcnt  <= w_wait;
         end else if (r_state == S_WAIT) begin
            r_wcnt <= r_wcnt - 3'd1;
         end
         if (w_commit && !w_c_wr) begin
            r_rdata <= w_c_oor ? '0 : r_mem[w_c_idx];
         end
      end
   end

   // Memory array is deliberately outside reset; a reset edge never commits
   always_ff @(posedge clk) begin
      if (rst_n && w_commit && w_c_wr && !w_c_oor) begin
         for (int i = 0; i < c_nbe; i++) begin
            if (w_c_be[i]) begin
               r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
            end
         end
      end
   end

   assign ack         = (r_state == S_ACK);
   assign busy        = (r_state == S_WAIT);
   assign rdata_valid = ack & ~r_wr;
   assign err         = ack & r_oor;
   assign rdata       = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ws.sv
// ============================================================================
// Module   : tb_dmem_ws
// Brief    : Scoreboard bench for dmem_ws; instance 0 has WS=0, instance 1
//            has WS=3 (WS=7 with DMEM_RANDOM_WS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ws;

`ifdef DMEM_RANDOM_WS_EN
   localparam int WS_B = 7;
`else
   localparam int WS_B = 3;
`endif
   localparam int TMO = 50;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic [1:0]  rst_n, en, wr, rdata_valid, ack, busy, err;
   logic [31:0] addr  [2];
   logic [3:0]  be    [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];

   logic [31:0] model [2][1024];
   exp_t        sb0 [$];
   exp_t        sb1 [$];
   int          checks;
   int          failures;

   dmem_ws #(.ADDR_W(10), .DATA_W(32), .WS(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .wr(wr[0]), .addr(addr[0]),
      .be(be[0]), .wdata(wdata[0]), .rdata(rdata[0]),
      .rdata_valid(rdata_valid[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
   );

   dmem_ws #(.ADDR_W(10), .DATA_W(32), .WS(WS_B)) u_ws1 (
      .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .wr(wr[1]), .addr(addr[1]),
      .be(be[1]), .wdata(wdata[1]), .rdata(rdata[1]),
      .rdata_valid(rdata_valid[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected result is computed from the bench's own memory model at issue time
   task automatic push_exp(input int d, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] wd);
      exp_t        e;
      logic [9:0]  idx;
      idx    = a[11:2];
      e.wr   = w;
      e.err  = |a[31:12];
      e.data = e.err ? 32'h0 : model[d][idx];
      if (w && !e.err) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic set_req(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd);
      en[d] = 1'b1; wr[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
   endtask

   // Presents a request and returns in its ack cycle; cyc = edges until ack
   task automatic do_req(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd, output int cyc);
      push_exp(d, w, a, b, wd);
      set_req(d, w, a, b, wd);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!ack[d] && cyc < TMO);
      if (cyc >= TMO) chk($sformatf("d%0d_ack_timeout", d), 32'(ack[d]), 32'd1);
   endtask

   task automatic idle(input int d);
      en[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic mon(input int d);
      exp_t e;
      int   n;
      if (ack[d]) begin
         n = (d == 0) ? sb0.size() : sb1.size();
         if (n == 0) begin
            chk($sformatf("d%0d_spurious_ack", d), 32'(ack[d]), 32'd0);
         end else begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("d%0d_err", d), 32'(err[d]), 32'(e.err));
            chk($sformatf("d%0d_rdata_valid", d), 32'(rdata_valid[d]), 32'(!e.wr));
            if (!e.wr) chk($sformatf("d%0d_rdata", d), rdata[d], e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   initial begin
      int cyc;
      checks   = 0;
      failures = 0;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; en[d] = 1'b0; wr[d] = 1'b0;
         addr[d] = '0; be[d] = '0; wdata[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_rdata", d), rdata[d], 32'h0);
         chk($sformatf("d%0d_rst_ack", d), 32'(ack[d]), 32'd0);
         chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
         chk($sformatf("d%0d_rst_err", d), 32'(err[d]), 32'd0);
         chk($sformatf("d%0d_rst_rvalid", d), 32'(rdata_valid[d]), 32'd0);
      end
      rst_n = 2'b11;
      @(posedge clk); #1;

      // WS=0: write then read in the write's ack cycle
      do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, cyc);
      chk("ws0_wr_lat", cyc, 1);
      do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, cyc);
      chk("ws0_rd_lat", cyc, 1);
      idle(0);
      chk("ws0_rd_hold", rdata[0], 32'hDEADBEEF);

      // Byte lanes
      do_req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, cyc);
      do_req(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, cyc);
      do_req(0, 1'b0, 32'h20, 4'h0, 32'h0, cyc);
      idle(0);
      chk("be_merge", rdata[0], 32'h11BB33DD);

      // Out of range
      do_req(0, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, cyc);
      do_req(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, cyc);
      do_req(0, 1'b0, 32'h1000, 4'h0, 32'h0, cyc);
      idle(0);
      chk("oor_rdata", rdata[0], 32'h0);
      do_req(0, 1'b0, 32'h0, 4'h0, 32'h0, cyc);
      idle(0);
      chk("oor_word0", rdata[0], 32'h0BADF00D);

`ifdef DMEM_RANDOM_WS_EN
      begin
         logic [7:0] l;
         for (int i = 0; i < 8; i++) begin
            do_req(1, 1'b1, 32'(i * 4), 4'hF, 32'hA5000000 + 32'(i), cyc);
         end
         idle(1);
         rst_n[1] = 1'b0;
         @(posedge clk); #1;
         rst_n[1] = 1'b1;
         l = 8'h01;
         for (int i = 0; i < 8; i++) begin
            do_req(1, 1'b0, 32'(i * 4), 4'h0, 32'h0, cyc);
            chk($sformatf("rand_lat%0d", i), cyc, 32'(l[2:0]) + 1);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
         end
         idle(1);
      end
`else
      // WS=3 timing
      do_req(1, 1'b1, 32'h40, 4'hF, 32'h0F0E0D0C, cyc);
      chk("ws3_wr_lat", cyc, 4);
      idle(1);
      push_exp(1, 1'b0, 32'h40, 4'h0, 32'h0);
      set_req(1, 1'b0, 32'h40, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("ws3_busy%0d", i), 32'(busy[1]), 32'd1);
         chk($sformatf("ws3_noack%0d", i), 32'(ack[1]), 32'd0);
      end
      @(posedge clk); #1;
      chk("ws3_ack", 32'(ack[1]), 32'd1);
      chk("ws3_rvalid", 32'(rdata_valid[1]), 32'd1);
      chk("ws3_busy_ack", 32'(busy[1]), 32'd0);
      chk("ws3_rdata", rdata[1], 32'h0F0E0D0C);
      idle(1);

      // Reset during a pending write
      do_req(1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, cyc);
      do_req(1, 1'b0, 32'h0, 4'h0, 32'h0, cyc);
      idle(1);
      set_req(1, 1'b1, 32'h0, 4'hF, 32'h5A5A5A5A);
      @(posedge clk); #1;
      chk("rst_mid_busy", 32'(busy[1]), 32'd1);
      rst_n[1] = 1'b0;
      en[1]    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rst_mid_ack%0d", i), 32'(ack[1]), 32'd0);
      end
      chk("rst_mid_busy0", 32'(busy[1]), 32'd0);
      chk("rst_mid_err", 32'(err[1]), 32'd0);
      chk("rst_mid_rvalid", 32'(rdata_valid[1]), 32'd0);
      chk("rst_mid_rdata", rdata[1], 32'h0);
      rst_n[1] = 1'b1;
      @(posedge clk); #1;
      do_req(1, 1'b0, 32'h0, 4'h0, 32'h0, cyc);
      idle(1);
      chk("rst_mid_keep", rdata[1], 32'hCAFEF00D);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
